alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
Pipeline stage directly upstream of the 32-bit RISC-V ALU. It decodes RV32I integer-computational instructions (OP, OP-IMM, LUI, AUIPC) into the ALU operand pair A/B and the 4-bit ALUCtl code, then registers them. It uses a valid/ready handshake with a 2-entry skid buffer, so in_ready is a registered signal and back-to-back issue runs at full throughput.

Parameters:
XLEN, 32, datapath width of operands and PC.
CNT_W, 16, width of the issued-instruction counter.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  upstream beat valid.
in_ready  output  1  stage can accept a beat; registered.
instr  input  32  raw instruction word.
pc  input  XLEN  instruction address (used by AUIPC).
rs1_data  input  XLEN  register-file read port 1.
rs2_data  input  XLEN  register-file read port 2.
out_valid  output  1  A/B/ALUCtl/rd/illegal are valid.
out_ready  input  1  ALU side accepts the beat.
A  output  XLEN  ALU operand A.
B  output  XLEN  ALU operand B.
ALUCtl  output  4  ALU operation code.
rd  output  5  destination register index, passed through.
illegal  output  1  instruction was not decodable.
issued_cnt  output  CNT_W  count of beats accepted on the output handshake.

Behaviour:
- Reset (async assert, sync-free deassert): out_valid=0, in_ready=1, A=B=0, ALUCtl=4'b0000, rd=0, illegal=0, issued_cnt=0, skid buffer empty.
- ALUCtl encoding:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 XOR
  - 0100 SLL, 0101 SRL, 0110 SUB, 0111 SLT
  - 1000 SLTU, 1001 SRA
  - All other codes are never produced.
- OP (0110011):
  - A=rs1_data, B=rs2_data.
  - funct3/funct7 select ALUCtl: 000/0000000 ADD, 000/0100000 SUB, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101/0000000 SRL, 101/0100000 SRA, 110 OR, 111 AND.
  - Any other funct7 for a given funct3 is illegal.
- OP-IMM (0010011):
  - A=rs1_data, B=sign-extended instr[31:20]; same funct3 mapping, never SUB.
  - Shifts (funct3 001/101): B={27'b0, instr[24:20]}; instr[31:25] must be 0000000, or 0100000 for SRAI only. Otherwise illegal.
- LUI (0110111): A=0, B={instr[31:12],12'b0}, ALUCtl=ADD.
- AUIPC (0010111): A=pc, B={instr[31:12],12'b0}, ALUCtl=ADD.
- Illegal instruction: any other opcode or bad funct7. The beat still issues, with A=0, B=0, ALUCtl=ADD, illegal=1, rd=instr[11:7]. It is never dropped.
- Latency: 1 cycle from an accepted input (in_valid&in_ready) to out_valid, when the output register is free.
- Output register loads when (!out_valid | out_ready).
  - On accept with a stalled output (out_valid & !out_ready): the decoded beat goes to the skid register.
  - Next cycle, in_ready=0.
- Skid drain: when out_ready=1 and the skid register is full, skid moves to the output register and in_ready returns to 1 on the following cycle.
- No new accept can happen while the skid register is full.
- Ordering: strict FIFO. No duplication or loss under any out_ready pattern.
- Output hold: outputs are stable while out_valid & !out_ready.
- Simultaneous events: accept and output handshake in the same cycle with an empty skid register → the new beat loads the output register directly, so out_valid stays 1.
- issued_cnt: increments on each out_valid&out_ready and wraps from 2^CNT_W-1 to 0.
- Reset mid-operation: all in-flight beats, including the skid entry, are discarded immediately on rst_n low.

Test Plan:
- add x3,x1,x2 (0x002081B3), rs1=100, rs2=40, out_ready=1 → next cycle out_valid=1, A=100, B=40, ALUCtl=0010, rd=3, illegal=0, then issued_cnt=1.
- sub x2,x1,x2 (0x40208133), rs1=0xFFFFFFFE, rs2=0xFFFFFFFF → A=0xFFFFFFFE, B=0xFFFFFFFF, ALUCtl=0110. Then addi x5,x0,-1 (0xFFF00293) → B=0xFFFFFFFF, ALUCtl=0010.
- srai x1,x1,4 (0x4040D093) → ALUCtl=1001, B=4. lui x1,0x12345 (0x123450B7) → A=0, B=0x12345000. auipc with pc=0x100 (0x00001097) → A=0x100, B=0x1000.
- Backpressure: out_ready=0, three consecutive valid beats (add, sub, xor):
  - beat 1 is held in the output register, beat 2 goes to skid, in_ready=0, beat 3 is held upstream.
  - Raise out_ready → add, sub, xor emerge in order on consecutive cycles; issued_cnt=3.
- Illegal: mul x1,x2,x3 (0x023100B3) and opcode 0x00 → illegal=1, A=0, B=0, ALUCtl=0010; the beat still handshakes.
- Reset: drive rst_n low while both registers are full → out_valid=0 and in_ready=1 asynchronously, with no clock edge. After release, the next beat issues with 1-cycle latency.

Source files
------------

// File: rtl/alu_issue_stage.sv
// Issue stage in front of the RV32I ALU: decodes OP/OP-IMM/LUI/AUIPC into A/B/ALUCtl
// and registers the result behind a valid/ready handshake with a one-entry skid register.
module alu_issue_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic [XLEN-1:0]  rs2_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  A,
    output logic [XLEN-1:0]  B,
    output logic [3:0]       ALUCtl,
    output logic [4:0]       rd,
    output logic             illegal,
    output logic [CNT_W-1:0] issued_cnt
);

    // Handshake: a beat transfers on a rising edge where valid & ready are both high;
    // a producer holds valid and its data stable until that edge, and ready never
    // depends combinationally on valid (in_ready is a flop).

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [3:0]      ctl;
        logic [4:0]      rd;
        logic            ill;
    } beat_t;

    function automatic logic [3:0] base_ctl(input logic [2:0] f3);
        case (f3)
            3'b000:  base_ctl = ALU_ADD;
            3'b001:  base_ctl = ALU_SLL;
            3'b010:  base_ctl = ALU_SLT;
            3'b011:  base_ctl = ALU_SLTU;
            3'b100:  base_ctl = ALU_XOR;
            3'b101:  base_ctl = ALU_SRL;
            3'b110:  base_ctl = ALU_OR;
            default: base_ctl = ALU_AND;
        endcase
    endfunction

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] shamt;
    logic            bad;
    beat_t           dec;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign imm_i  = XLEN'($signed(instr[31:20]));
    assign imm_u  = XLEN'($signed({instr[31:12], 12'b0}));
    assign shamt  = XLEN'(instr[24:20]);

    always_comb begin
        dec     = '0;
        dec.rd  = instr[11:7];
        dec.ctl = ALU_ADD;
        bad     = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec.a = rs1_data;
                dec.b = rs2_data;
                case (funct3)
                    3'b000: begin
                        if (funct7 == F7_BASE)     dec.ctl = ALU_ADD;
                        else if (funct7 == F7_ALT) dec.ctl = ALU_SUB;
                        else                       bad = 1'b1;
                    end
                    3'b101: begin
                        if (funct7 == F7_BASE)     dec.ctl = ALU_SRL;
                        else if (funct7 == F7_ALT) dec.ctl = ALU_SRA;
                        else                       bad = 1'b1;
                    end
                    default: begin
                        dec.ctl = base_ctl(funct3);
                        bad     = (funct7 != F7_BASE);
                    end
                endcase
            end
            OPC_OP_IMM: begin
                dec.a = rs1_data;
                dec.b = imm_i;
                case (funct3)
                    3'b001: begin
                        dec.b   = shamt;
                        dec.ctl = ALU_SLL;
                        bad     = (funct7 != F7_BASE);
                    end
                    3'b101: begin
                        dec.b = shamt;
                        if (funct7 == F7_BASE)     dec.ctl = ALU_SRL;
                        else if (funct7 == F7_ALT) dec.ctl = ALU_SRA;
                        else                       bad = 1'b1;
                    end
                    default: dec.ctl = base_ctl(funct3);
                endcase
            end
            OPC_LUI: begin
                dec.a = '0;
                dec.b = imm_u;
            end
            OPC_AUIPC: begin
                dec.a = pc;
                dec.b = imm_u;
            end
            default: bad = 1'b1;
        endcase
        // Undecodable beats still flow downstream so the pipeline can trap in order.
        if (bad) begin
            dec.a   = '0;
            dec.b   = '0;
            dec.ctl = ALU_ADD;
            dec.ill = 1'b1;
        end
    end

    beat_t            out_q;
    beat_t            skid_q;
    logic             out_valid_q;
    logic             skid_valid_q;
    logic             in_ready_q;
    logic [CNT_W-1:0] cnt_q;

    logic accept;
    logic out_fire;
    logic out_free;

    assign accept   = in_valid & in_ready_q;
    assign out_fire = out_valid_q & out_ready;
    assign out_free = ~out_valid_q | out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else if (skid_valid_q) begin
            // in_ready is low here, so no new beat can arrive while draining.
            if (out_ready) begin
                out_q        <= skid_q;
                skid_valid_q <= 1'b0;
                in_ready_q   <= 1'b1;
            end
        end else if (accept) begin
            if (out_free) begin
                out_q       <= dec;
                out_valid_q <= 1'b1;
            end else begin
                skid_q       <= dec;
                skid_valid_q <= 1'b1;
                in_ready_q   <= 1'b0;
            end
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        cnt_q <= '0;
        else if (out_fire) cnt_q <= cnt_q + 1'b1;
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign A          = out_q.a;
    assign B          = out_q.b;
    assign ALUCtl     = out_q.ctl;
    assign rd         = out_q.rd;
    assign illegal    = out_q.ill;
    assign issued_cnt = cnt_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode vectors, backpressure/skid ordering,
// illegal-instruction pass-through and asynchronous reset with both registers full.
module tb_alu_issue_stage;

    localparam int XLEN  = 32;
    localparam int CNT_W = 16;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      instr;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  rs1_data;
    logic [XLEN-1:0]  rs2_data;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  A;
    logic [XLEN-1:0]  B;
    logic [3:0]       ALUCtl;
    logic [4:0]       rd;
    logic             illegal;
    logic [CNT_W-1:0] issued_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int exp_cnt = 0;
    logic [73:0] exp_q[$];

    alu_issue_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .A(A), .B(B), .ALUCtl(ALUCtl), .rd(rd), .illegal(illegal),
        .issued_cnt(issued_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [73:0] pack(input logic ill, input logic [4:0] r,
                                         input logic [3:0] ctl,
                                         input logic [31:0] a, input logic [31:0] b);
        pack = {ill, r, ctl, a, b};
    endfunction

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Compare the beat on the output port; out_ready is assumed high so it fires next edge.
    task automatic check_beat(input string tag, input logic [31:0] a, input logic [31:0] b,
                              input logic [3:0] ctl, input logic [4:0] r, input logic ill);
        check({tag, "_valid"}, 96'(out_valid), 96'(1));
        check(tag, 96'(pack(illegal, rd, ALUCtl, A, B)), 96'(pack(ill, r, ctl, a, b)));
        exp_cnt++;
    endtask

    // driver: present one beat at a negedge, hold until accepted, return at the next negedge
    task automatic drive(input logic [31:0] i, input logic [31:0] p,
                         input logic [31:0] r1, input logic [31:0] r2);
        int n;
        in_valid = 1'b1;
        instr    = i;
        pc       = p;
        rs1_data = r1;
        rs2_data = r2;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("drive_timeout", 96'(in_ready), 96'(1));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        int  guard;
        logic took;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        instr     = '0;
        pc        = '0;
        rs1_data  = '0;
        rs2_data  = '0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 96'(out_valid), 96'(0));
        check("rst_in_ready", 96'(in_ready), 96'(1));
        check("rst_outputs", 96'(pack(illegal, rd, ALUCtl, A, B)), 96'(0));
        check("rst_cnt", 96'(issued_cnt), 96'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // single beat, 1-cycle latency
        out_ready = 1'b1;
        drive(32'h002081B3, 32'h0, 32'd100, 32'd40);
        check("add_cnt_before", 96'(issued_cnt), 96'(0));
        check_beat("add", 32'd100, 32'd40, 4'b0010, 5'd3, 1'b0);
        @(negedge clk);
        check("add_idle_valid", 96'(out_valid), 96'(0));
        check("add_cnt", 96'(issued_cnt), 96'(exp_cnt));

        // back-to-back decode vectors
        drive(32'h40208133, 32'h0, 32'hFFFFFFFE, 32'hFFFFFFFF);
        check_beat("sub", 32'hFFFFFFFE, 32'hFFFFFFFF, 4'b0110, 5'd2, 1'b0);
        drive(32'hFFF00293, 32'h0, 32'h0, 32'h1234);
        check_beat("addi_neg", 32'h0, 32'hFFFFFFFF, 4'b0010, 5'd5, 1'b0);
        drive(32'h0020C233, 32'h0, 32'hA5A5A5A5, 32'h0F0F0F0F);
        check_beat("xor", 32'hA5A5A5A5, 32'h0F0F0F0F, 4'b0011, 5'd4, 1'b0);
        drive(32'h4040D093, 32'h0, 32'h80000000, 32'hDEADBEEF);
        check_beat("srai", 32'h80000000, 32'd4, 4'b1001, 5'd1, 1'b0);
        drive(32'h123450B7, 32'h0, 32'h55555555, 32'h0);
        check_beat("lui", 32'h0, 32'h12345000, 4'b0010, 5'd1, 1'b0);
        drive(32'h00001097, 32'h100, 32'h77, 32'h0);
        check_beat("auipc", 32'h100, 32'h1000, 4'b0010, 5'd1, 1'b0);
        drive(32'hFFF0B313, 32'h0, 32'd1, 32'h0);
        check_beat("sltiu", 32'd1, 32'hFFFFFFFF, 4'b1000, 5'd6, 1'b0);
        drive(32'h00109093, 32'h0, 32'h3, 32'h0);
        check_beat("slli", 32'h3, 32'd1, 4'b0100, 5'd1, 1'b0);
        drive(32'h40109093, 32'h0, 32'h3, 32'h0);
        check_beat("slli_bad_f7", 32'h0, 32'h0, 4'b0010, 5'd1, 1'b1);
        drive(32'h023100B3, 32'h0, 32'h11, 32'h22);
        check_beat("mul_illegal", 32'h0, 32'h0, 4'b0010, 5'd1, 1'b1);
        drive(32'h00000F80, 32'h40, 32'h11, 32'h22);
        check_beat("opc0_illegal", 32'h0, 32'h0, 4'b0010, 5'd31, 1'b1);
        @(negedge clk);
        check("seq_idle_valid", 96'(out_valid), 96'(0));
        check("seq_cnt", 96'(issued_cnt), 96'(exp_cnt));

        // backpressure: add in output reg, sub in skid, xor held upstream
        out_ready = 1'b0;
        exp_q.push_back(pack(1'b0, 5'd3, 4'b0010, 32'd1, 32'd2));
        exp_q.push_back(pack(1'b0, 5'd2, 4'b0110, 32'd9, 32'd4));
        exp_q.push_back(pack(1'b0, 5'd4, 4'b0011, 32'hF0, 32'hFF));
        drive(32'h002081B3, 32'h0, 32'd1, 32'd2);
        drive(32'h40208133, 32'h0, 32'd9, 32'd4);
        check("bp_in_ready_low", 96'(in_ready), 96'(0));
        in_valid = 1'b1;
        instr    = 32'h0020C233;
        rs1_data = 32'hF0;
        rs2_data = 32'hFF;
        @(negedge clk);
        check("bp_hold_valid", 96'(out_valid), 96'(1));
        check("bp_hold_beat", 96'(pack(illegal, rd, ALUCtl, A, B)), 96'(exp_q[0]));
        check("bp_still_blocked", 96'(in_ready), 96'(0));
        out_ready = 1'b1;
        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            took = in_valid & in_ready;
            check("bp_drain_valid", 96'(out_valid), 96'(1));
            check("bp_drain_beat", 96'(pack(illegal, rd, ALUCtl, A, B)), 96'(exp_q.pop_front()));
            exp_cnt++;
            @(negedge clk);
            if (took) in_valid = 1'b0;
            guard++;
        end
        check("bp_drained", 96'(exp_q.size()), 96'(0));
        check("bp_idle_valid", 96'(out_valid), 96'(0));
        check("bp_cnt", 96'(issued_cnt), 96'(exp_cnt));

        // asynchronous reset with both registers full
        out_ready = 1'b0;
        drive(32'h002081B3, 32'h0, 32'd5, 32'd6);
        drive(32'h40208133, 32'h0, 32'd7, 32'd8);
        check("rr_full_in_ready", 96'(in_ready), 96'(0));
        #2 rst_n = 1'b0;
        #1;
        check("rr_async_out_valid", 96'(out_valid), 96'(0));
        check("rr_async_in_ready", 96'(in_ready), 96'(1));
        check("rr_async_cnt", 96'(issued_cnt), 96'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rr_post_valid", 96'(out_valid), 96'(0));
        out_ready = 1'b1;
        exp_cnt = 0;
        drive(32'h002081B3, 32'h0, 32'd7, 32'd8);
        check_beat("rr_add", 32'd7, 32'd8, 4'b0010, 5'd3, 1'b0);
        @(negedge clk);
        check("rr_cnt", 96'(issued_cnt), 96'(exp_cnt));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
